fetch_pc_unit: RTL

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit_if.sv | 31 +++
 rtl/fetch_pc_unit.sv | 83 ++++++++
 2 files changed

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: signal bundle between the fetch PC unit and its neighbours
// (hazard unit, branch predictor, ID-stage resolution).
//   master : hazard/predictor/ID side, drives stall, flush, prediction and redirect
//   slave  : fetch_pc_unit, drives pc_f, pc_d, valid_d, pred_taken_d, redirect_count
interface fetch_pc_unit_if;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        bht_taken;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        pred_taken_d;
    logic [31:0] redirect_count;

    modport master (
        output stall_f, stall_d, flush_d, bht_taken, btb_hit, btb_target,
               redirect_valid, redirect_pc,
        input  pc_f, pc_d, valid_d, pred_taken_d, redirect_count
    );

    modport slave (
        input  stall_f, stall_d, flush_d, bht_taken, btb_hit, btb_target,
               redirect_valid, redirect_pc,
        output pc_f, pc_d, valid_d, pred_taken_d, redirect_count
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF-stage program counter plus the IF/ID pipeline register.
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : fetch_pc_unit_if.slave
//     in  : stall_f, stall_d, flush_d, bht_taken, btb_hit, btb_target,
//           redirect_valid, redirect_pc
//     out : pc_f, pc_d, valid_d, pred_taken_d, redirect_count
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_unit_if.slave  bus
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_f_q;
    logic [31:0] pc_d_q;
    logic        valid_d_q;
    logic        pred_taken_d_q;
    logic [31:0] redirect_count_q;

    logic        pred_taken_f;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;

    assign pred_taken_f = bus.bht_taken & bus.btb_hit;
    assign pc_plus4     = pc_f_q + 32'd4;

    // Redirect outranks stall: a mispredict must win even while IF is held.
    always_comb begin
        next_pc_raw = pc_plus4;
        if (bus.redirect_valid)
            next_pc_raw = bus.redirect_pc;
        else if (bus.stall_f)
            next_pc_raw = pc_f_q;
        else if (pred_taken_f)
            next_pc_raw = bus.btb_target;
    end

    assign next_pc = {next_pc_raw[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q <= RESET_PC_ALIGNED;
        end else begin
            pc_f_q <= next_pc;
        end
    end

    // A bubble keeps pc_d so the BHT update index stays stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_d_q         <= 32'h0000_0000;
            valid_d_q      <= 1'b0;
            pred_taken_d_q <= 1'b0;
        end else if (bus.redirect_valid || bus.flush_d) begin
            valid_d_q      <= 1'b0;
            pred_taken_d_q <= 1'b0;
        end else if (!bus.stall_d) begin
            pc_d_q         <= pc_f_q;
            pred_taken_d_q <= pred_taken_f;
            valid_d_q      <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_count_q <= 32'h0000_0000;
        end else if (bus.redirect_valid) begin
            redirect_count_q <= redirect_count_q + 32'd1;
        end
    end

    assign bus.pc_f           = pc_f_q;
    assign bus.pc_d           = pc_d_q;
    assign bus.valid_d        = valid_d_q;
    assign bus.pred_taken_d   = pred_taken_d_q;
    assign bus.redirect_count = redirect_count_q;

endmodule
